// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and FSM state encoding for the UART transmit arbiter.
package uart_pkg;
   localparam int DATA_W_DEF      = 8;
   localparam int WDOG_CYCLES_DEF = 64;
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      START       = 2'd1,
      WAIT_ACCEPT = 2'd2,
      WAIT_DONE   = 2'd3
   } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; the first set req after last_i wins, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_i,
   output logic [IDW-1:0]  winner_o,
   output logic            valid_o
);
   always_comb begin
      int best;
      best     = NREQ;
      winner_o = '0;
      for (int j = 0; j < NREQ; j++) begin
         // distance from last_i+1 going upward; smallest distance has priority
         if (req_i[j] && ((j + NREQ - 1 - int'(last_i)) % NREQ) < best) begin
            best     = (j + NREQ - 1 - int'(last_i)) % NREQ;
            winner_o = IDW'(j);
         end
      end
      valid_o = |req_i;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ byte requesters.
// Define UART_ARB_WDOG_EN to add a watchdog on tx_busy rising after tx_start (sets wdog_err).
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDW    = 2
`ifdef UART_ARB_WDOG_EN
   , parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] data_in,
   output logic [NREQ-1:0]        ack,
   output logic                   tx_start,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_busy,
   output logic [IDW-1:0]         grant_id,
   output logic                   arb_busy,
   output logic                   wdog_err
);
   arb_state_e        state_q, state_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [IDW-1:0]    grant_q, grant_d, winner;
   logic              valid;
`ifdef UART_ARB_WDOG_EN
   localparam int WDW = $clog2(WDOG_CYCLES + 1);
   logic [WDW-1:0] wdog_q, wdog_d;
   logic           wdog_err_q, wdog_err_d;
   assign wdog_err = wdog_err_q;
`else
   assign wdog_err = 1'b0;
`endif

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_i   (req),
      .last_i  (grant_q),
      .winner_o(winner),
      .valid_o (valid)
   );

   assign tx_data  = tx_data_q;
   assign grant_id = grant_q;
   assign arb_busy = state_q != IDLE;

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      ack       = '0;
      tx_start  = 1'b0;
`ifdef UART_ARB_WDOG_EN
      wdog_d     = (state_q == WAIT_ACCEPT) ? wdog_q + 1'b1 : '0;
      wdog_err_d = wdog_err_q;
`endif
      unique case (state_q)
         IDLE: if (valid && !tx_busy) begin
            tx_data_d = data_in[winner*DATA_W +: DATA_W];
            grant_d   = winner;
            state_d   = START;
         end
         START: begin
            tx_start = 1'b1;
            state_d  = WAIT_ACCEPT;
         end
         WAIT_ACCEPT: if (tx_busy) begin
            ack     = NREQ'(1) << grant_q;
            state_d = WAIT_DONE;
         end
`ifdef UART_ARB_WDOG_EN
         else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
            wdog_err_d = 1'b1;
            state_d    = IDLE;
         end
`endif
         WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         grant_q    <= IDW'(NREQ - 1);
`ifdef UART_ARB_WDOG_EN
         wdog_q     <= '0;
         wdog_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
`ifdef UART_ARB_WDOG_EN
         wdog_q     <= wdog_d;
         wdog_err_q <= wdog_err_d;
`endif
      end
   end
endmodule
